exe_mem_req: RTL
================

EXE_MEM_REQ -- requirements
Module: exe_mem_req

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 resetn  in  1  reset; asynchronous, active-low.
REQ-003 es_valid  in  1  the EX stage holds a valid instruction.
REQ-004 es_mem_re / es_mem_we  in  1/1  the EX instruction is a load / store; they are never both 1.
REQ-005 es_mem_size  in  2  access size: 00 byte, 01 half, 10 word.
REQ-006 es_addr / es_st_data  in  32/32  effective address / raw store data (low bits significant).
REQ-007 es_ex_in  in  1  an earlier exception is already attached to the EX instruction.
REQ-008 ms_allowin  in  1  the MEM stage can accept an instruction.
REQ-009 wb_ex  in  1  pipeline flush from WB.
REQ-010 data_sram_req, data_sram_wr  out  1/1  request valid / write request.
REQ-011 data_sram_size  out  2  copy of es_mem_size.
REQ-012 data_sram_wstrb  out  4  byte enables; 0000 for loads.
REQ-013 data_sram_addr, data_sram_wdata  out  32/32  request address / aligned store data.
REQ-014 data_sram_addr_ok, data_sram_data_ok  in  1/1  request accepted / response returned.
REQ-015 es_mem_ready_go  out  1  this block lets the EX instruction leave EX.
REQ-016 es_wait_data_ok  out  1  the leaving instruction owns an accepted request; it goes on the EX-to-MEM bus.
REQ-017 es_ale  out  1  address-misalignment exception for the EX instruction.
REQ-018 ms_data_ok  out  1  data_sram_data_ok with cancelled responses filtered out.

Function
REQ-019 memop = es_valid & (es_mem_re | es_mem_we); issue_ok = memop & ~es_ex_in & ~es_ale & ~wb_ex & ms_allowin & (discard_cnt != 3).
REQ-020 The FSM has three states: IDLE, REQ (req high, waiting for addr_ok) and ACC (accepted, waiting for the instruction to leave EX).
REQ-021 IDLE: when issue_ok, data_sram_req=1 combinationally. If addr_ok=1 in that cycle, go to ACC, unless the instruction leaves in that cycle, in which case stay in IDLE. Otherwise go to REQ.
REQ-022 REQ: req=1 and addr/size/wr/wstrb/wdata are held constant until addr_ok, even across wb_ex. On addr_ok go to ACC, or to IDLE if the instruction leaves in the same cycle or is flushed.
REQ-023 ACC: req=0; go to IDLE when es_valid & es_mem_ready_go & ms_allowin, or when wb_ex=1.
REQ-024 es_mem_ready_go = ~memop | es_ex_in | es_ale | addr_ok-handshake this cycle | state==ACC.
REQ-025 es_wait_data_ok = 1 in ACC, or when the addr_ok handshake completes this cycle; otherwise 0.
REQ-026 The request for one EX instruction is issued at most once. A new instruction gets its first request no earlier than the cycle after the previous one leaves EX.
REQ-027 wstrb: byte = 0001 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111. wdata: byte = 4 copies of [7:0], half = 2 copies of [15:0], word = unchanged.
REQ-028 discard_cnt (2-bit) counts accepted requests whose instruction was flushed by wb_ex before leaving EX, in the ACC state or in the addr_ok cycle.
REQ-029 On data_ok with discard_cnt != 0: decrement the counter; ms_data_ok=0.
REQ-030 Otherwise ms_data_ok = data_sram_data_ok.
REQ-031 If an increment and a decrement occur in the same cycle, the counter is unchanged.
REQ-032 When discard_cnt == 3, no new request is issued (back-pressure via es_mem_ready_go=0).

Reset
REQ-033 Assertion of resetn=0 asynchronously forces state=IDLE and discard_cnt=0.
REQ-034 During reset, data_sram_req=0 and ms_data_ok=0.
REQ-035 Outputs return to normal function on the first clk edge after resetn deasserts.
REQ-036 A reset that arrives in REQ abandons the request; the SRAM side is reset together.

Configuration
REQ-037 Macro DATA_REQ_ALE_EN.
REQ-038 When DATA_REQ_ALE_EN is defined: es_ale = memop & (half & addr[0] | word & |addr[1:0]), and no request is issued for that instruction.
REQ-039 When DATA_REQ_ALE_EN is undefined: es_ale is tied to 0 and misaligned requests are issued unchanged.

Verification
REQ-040 Word store to 0x1000, data 0xAABBCCDD, addr_ok in the same cycle, ms_allowin=1 -> one req cycle, wstrb=1111, es_wait_data_ok=1, state stays IDLE.
REQ-041 Byte store to 0x1003, data 0x000000EE, addr_ok 3 cycles late -> req held 4 cycles with stable addr, wstrb=1000, wdata=0xEEEEEEEE.
REQ-042 Load accepted, ms_allowin=0 for 2 cycles -> ACC is held with req=0, then exits on ms_allowin=1 with no second request.
REQ-043 Load accepted, wb_ex pulses in ACC -> discard_cnt=1. Next data_ok -> ms_data_ok=0, discard_cnt=0. The following data_ok passes through.
REQ-044 Half-word load to 0x2001 with DATA_REQ_ALE_EN -> es_ale=1, req=0, es_mem_ready_go=1. Without the macro -> req=1, es_ale=0.
REQ-045 resetn driven low mid-REQ, between clock edges -> req drops immediately, and discard_cnt=0.

Source files
------------

// File: rtl/exe_mem_req.sv
// exe_mem_req: EX-stage data SRAM request issue.
// Issues one request per memory instruction in EX, with a three-state FSM:
// IDLE (no request pending), REQ (request raised, waiting for addr_ok) and
// ACC (request accepted, waiting for the instruction to leave EX).
// It counts accepted requests whose instruction was flushed, and filters
// their data_ok responses out of ms_data_ok.
// Optional feature macro: DATA_REQ_ALE_EN (misaligned-address exception).
module exe_mem_req (
   input  logic        clk,
   input  logic        resetn,
   input  logic        es_valid,
   input  logic        es_mem_re,
   input  logic        es_mem_we,
   input  logic [1:0]  es_mem_size,
   input  logic [31:0] es_addr,
   input  logic [31:0] es_st_data,
   input  logic        es_ex_in,
   input  logic        ms_allowin,
   input  logic        wb_ex,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   output logic        es_mem_ready_go,
   output logic        es_wait_data_ok,
   output logic        es_ale,
   output logic        ms_data_ok
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_ACC = 2'd2} state_t;

   state_t      state;
   logic [1:0]  discard_cnt;
   logic        req_flushed;

   logic        memop, issue_ok, hs, stale, own_hs, leave;
   logic        discard_inc, discard_dec;

   logic        cur_wr;
   logic [1:0]  cur_size;
   logic [3:0]  cur_wstrb;
   logic [31:0] cur_addr, cur_wdata;

   logic        hold_wr_p1;
   logic [1:0]  hold_size_p1;
   logic [3:0]  hold_wstrb_p1;
   logic [31:0] hold_addr_p1, hold_wdata_p1;

   function automatic logic [3:0] size_wstrb(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   size_wstrb = 4'b0001 << lo;
         2'b01:   size_wstrb = lo[1] ? 4'b1100 : 4'b0011;
         default: size_wstrb = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] size_wdata(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   size_wdata = {4{d[7:0]}};
         2'b01:   size_wdata = {2{d[15:0]}};
         default: size_wdata = d;
      endcase
   endfunction

   assign memop = es_valid & (es_mem_re | es_mem_we);

`ifdef DATA_REQ_ALE_EN
   assign es_ale = memop & (((es_mem_size == 2'b01) & es_addr[0]) |
                            ((es_mem_size == 2'b10) & (|es_addr[1:0])));
`else
   assign es_ale = 1'b0;
`endif

   assign issue_ok = memop & ~es_ex_in & ~es_ale & ~wb_ex & ms_allowin & (discard_cnt != 2'd3);

   // Request fields: live from EX while idle, frozen copy while waiting for addr_ok
   always_comb begin
      cur_wr    = es_mem_we;
      cur_size  = es_mem_size;
      cur_addr  = es_addr;
      cur_wstrb = es_mem_we ? size_wstrb(es_mem_size, es_addr[1:0]) : 4'b0000;
      cur_wdata = size_wdata(es_mem_size, es_st_data);
      if (state == S_REQ) begin
         cur_wr    = hold_wr_p1;
         cur_size  = hold_size_p1;
         cur_addr  = hold_addr_p1;
         cur_wstrb = hold_wstrb_p1;
         cur_wdata = hold_wdata_p1;
      end
   end

   assign data_sram_req   = resetn & ((state == S_REQ) | ((state == S_IDLE) & issue_ok));
   assign data_sram_wr    = cur_wr;
   assign data_sram_size  = cur_size;
   assign data_sram_addr  = cur_addr;
   assign data_sram_wstrb = cur_wstrb;
   assign data_sram_wdata = cur_wdata;

   // A handshake in REQ after a flush belongs to the dead instruction, not to whatever is now in EX
   assign hs     = data_sram_req & data_sram_addr_ok;
   assign stale  = (state == S_REQ) & (req_flushed | wb_ex);
   assign own_hs = hs & ~stale;

   assign es_mem_ready_go = ~memop | es_ex_in | es_ale | own_hs | (state == S_ACC);
   assign es_wait_data_ok = (state == S_ACC) | own_hs;
   assign leave           = es_valid & es_mem_ready_go & ms_allowin;

   assign discard_inc = ((state == S_ACC) & wb_ex) | ((state == S_REQ) & data_sram_addr_ok & (req_flushed | wb_ex));
   assign discard_dec = data_sram_data_ok & (discard_cnt != 2'd0);
   assign ms_data_ok  = resetn & data_sram_data_ok & (discard_cnt == 2'd0);

   // Request FSM, flush tracking and discarded-response counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         req_flushed <= 1'b0;
         discard_cnt <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               req_flushed <= 1'b0;
               if (issue_ok) begin
                  if (data_sram_addr_ok) state <= leave ? S_IDLE : S_ACC;
                  else                   state <= S_REQ;
               end
            end
            S_REQ: begin
               if (wb_ex) req_flushed <= 1'b1;
               if (data_sram_addr_ok) begin
                  if (leave | req_flushed | wb_ex) state <= S_IDLE;
                  else                             state <= S_ACC;
               end
            end
            S_ACC: begin
               if (wb_ex | leave) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (discard_inc & ~discard_dec & (discard_cnt != 2'd3))
            discard_cnt <= discard_cnt + 2'd1;
         else if (discard_dec & ~discard_inc)
            discard_cnt <= discard_cnt - 2'd1;
      end
   end

   // Freeze the request fields at issue so they stay stable until addr_ok
   always_ff @(posedge clk) begin
      if ((state == S_IDLE) & issue_ok) begin
         hold_wr_p1    <= cur_wr;
         hold_size_p1  <= cur_size;
         hold_addr_p1  <= cur_addr;
         hold_wstrb_p1 <= cur_wstrb;
         hold_wdata_p1 <= cur_wdata;
      end
   end

endmodule
